// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, in-order imem requests, prefetch FIFO and redirect flush.
// Define IFU_BYPASS_EN to forward a returning word to instr in the same cycle when the FIFO is empty.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_req,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic                        imem_ready,
  input  logic                        imem_rvalid,
  input  logic [DATA_W-1:0]           imem_rdata,
  input  logic                        redirect,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [DATA_W-1:0]           instr,
  output logic [ADDR_W-1:0]           instr_pc,
  output logic [5:0]                  op,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH_LIM = (PW+2)'(FIFO_DEPTH);

  typedef logic [PW:0] cnt_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] redirect_base;
  cnt_t              outstanding;
  cnt_t              drop;
  cnt_t              rd_ptr;
  cnt_t              wr_ptr;
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [PW+1:0]     owed;
  logic              fifo_empty;
  logic              issue;
  logic              resp_keep;
  logic              bypass_hit;
  logic              push;
  logic              pop;

  assign fifo_count    = wr_ptr - rd_ptr;
  assign fifo_empty    = (fifo_count == '0);
  assign redirect_base = redirect_pc & ~ADDR_W'(3);

  // Words already buffered plus words still owed never exceed the FIFO size, so a push always fits.
  assign owed      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req  = reset && !redirect && (owed < DEPTH_LIM);
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_ready;
  assign resp_keep = imem_rvalid && !redirect && (drop == '0);

`ifdef IFU_BYPASS_EN
  assign bypass_hit = fifo_empty && resp_keep;
`else
  assign bypass_hit = 1'b0;
`endif

  assign instr_valid = !fifo_empty || bypass_hit;
  assign pop         = !fifo_empty && instr_ready && !redirect;
  assign push        = resp_keep && !(bypass_hit && instr_ready);

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (!fifo_empty) begin
      instr    = data_mem[rd_ptr[PW-1:0]];
      instr_pc = pc_mem[rd_ptr[PW-1:0]];
    end else if (bypass_hit) begin
      instr    = imem_rdata;
      instr_pc = resp_pc;
    end
  end

  assign op = instr[DATA_W-1 -: 6];

  // A redirect discards the FIFO and marks every still-owed word, minus one arriving now, as stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_base;
      resp_pc     <= redirect_base;
      outstanding <= outstanding - cnt_t'(imem_rvalid);
      drop        <= outstanding - cnt_t'(imem_rvalid);
      rd_ptr      <= wr_ptr;
    end else begin
      if (issue)
        fetch_pc <= fetch_pc + ADDR_W'(4);
      outstanding <= outstanding + cnt_t'(issue) - cnt_t'(imem_rvalid);
      if (imem_rvalid && (drop != '0))
        drop <= drop - cnt_t'(1);
      if (resp_keep)
        resp_pc <= resp_pc + ADDR_W'(4);
      if (push)
        wr_ptr <= wr_ptr + cnt_t'(1);
      if (pop)
        rd_ptr <= rd_ptr + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr[PW-1:0]] <= imem_rdata;
      pc_mem[wr_ptr[PW-1:0]]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch/redirect scenarios against a latency-configurable memory.
// Expectations for the same-cycle forwarding scenario follow IFU_BYPASS_EN.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  op;
  logic [2:0]  fifo_count;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] exp_q[$];
  int          lat;
  int          cyc;
  int          issued;
  int          vectors;
  int          miscompares;

`ifdef IFU_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  instr_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .op(op), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[7:2], a[25:0]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: in-order responses, each arriving lat cycles after its issue cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      if (imem_req && imem_ready) begin
        pend.push_back('{addr: imem_addr, due: cyc + lat});
        issued++;
      end
      cyc++;
      #1;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        req_t r;
        r = pend.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(r.addr);
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every accepted instruction must match the next expected pc and its word.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_pop: got pc %h, expected none", instr_pc);
      end else begin
        logic [31:0] p;
        logic [31:0] w;
        p = exp_q.pop_front();
        w = mem_word(p);
        check_output("instr_pc", instr_pc, p);
        check_output("instr", instr, w);
        check_output("op", {26'h0, op}, {26'h0, w[31:26]});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    check_output("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check_output("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check_output("rst_fifo_count", {29'h0, fifo_count}, 32'h0);
    check_output("rst_instr", instr, 32'h0);
    check_output("rst_instr_pc", instr_pc, 32'h0);
    issued = 0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    next_cycle();
    imem_ready  = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    while ((exp_q.size() != 0 || pend.size() != 0 || instr_valid) && n < 40) begin
      next_cycle();
      n++;
    end
    check_output({name, "_leftover"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; issued = 0; lat = 1;
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; instr_ready = 1'b0;

    $display("[TB] streaming fetch, latency 1");
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
    lat = 1;
    do_reset();
    imem_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("t1_req", {31'h0, imem_req}, 32'h1);
      check_output("t1_addr", imem_addr, 32'(4 * i));
    end
    drain("t1");

    $display("[TB] backpressure fills FIFO");
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    do_reset();
    imem_ready = 1'b1; instr_ready = 1'b0;
    repeat (5) next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("t2_req_held", {31'h0, imem_req}, 32'h0);
      check_output("t2_count", {29'h0, fifo_count}, 32'h4);
      next_cycle();
    end
    check_output("t2_issued", issued, 32'h4);
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
    @(negedge clk);
    check_output("t2_req_again", {31'h0, imem_req}, 32'h1);
    check_output("t2_addr", imem_addr, 32'h10);
    drain("t2");

    $display("[TB] redirect with 3 outstanding");
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    lat = 4;
    do_reset();
    imem_ready = 1'b1; instr_ready = 1'b1;
    repeat (3) next_cycle();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    check_output("t3_req_in_redirect", {31'h0, imem_req}, 32'h0);
    check_output("t3_issued", issued, 32'h3);
    next_cycle();
    redirect = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    check_output("t3_req", {31'h0, imem_req}, 32'h1);
    check_output("t3_addr", imem_addr, 32'h100);
    repeat (4) next_cycle();
    imem_ready = 1'b0;
    drain("t3");

    $display("[TB] redirect colliding with response and pop");
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    lat = 2;
    do_reset();
    imem_ready = 1'b1; instr_ready = 1'b0;
    repeat (4) next_cycle();
    imem_ready = 1'b0; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    check_output("t4_count_before", {29'h0, fifo_count}, 32'h2);
    check_output("t4_rvalid", {31'h0, imem_rvalid}, 32'h1);
    next_cycle();
    redirect = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    check_output("t4_count_after", {29'h0, fifo_count}, 32'h0);
    check_output("t4_valid_after", {31'h0, instr_valid}, 32'h0);
    check_output("t4_addr", imem_addr, 32'h200);
    next_cycle();
    @(negedge clk);
    check_output("t4_addr2", imem_addr, 32'h204);
    next_cycle();
    imem_ready = 1'b0;
    drain("t4");

    $display("[TB] PC wrap");
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    lat = 1;
    do_reset();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    next_cycle();
    redirect = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    check_output("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    check_output("t5_addr_wrap", imem_addr, 32'h0);
    next_cycle();
    imem_ready = 1'b0;
    drain("t5");

    $display("[TB] empty-FIFO response latency");
    exp_q.push_back(32'h0);
    lat = 2;
    do_reset();
    imem_ready = 1'b1; instr_ready = 1'b1;
    next_cycle();
    imem_ready = 1'b0;
    @(negedge clk);
    check_output("t6_valid_c1", {31'h0, instr_valid}, 32'h0);
    next_cycle();
    @(negedge clk);
    check_output("t6_valid_rvalid_cycle", {31'h0, instr_valid}, {31'h0, BYP});
    check_output("t6_count_rvalid_cycle", {29'h0, fifo_count}, 32'h0);
    next_cycle();
    @(negedge clk);
    check_output("t6_valid_next", {31'h0, instr_valid}, {31'h0, !BYP});
    check_output("t6_count_next", {29'h0, fifo_count}, {31'h0, !BYP});
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
